// File: rtl/display_seq.sv
`default_nettype none
// =============================================================================
// display_seq : drives HEX message address and level bit from game events
// Rev 1.0
// =============================================================================
module display_seq #(
    parameter int T_LEVEL  = 50_000_000,
    parameter int T_BLINK  = 12_500_000,
    parameter int N_BLINKS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       nivel_in,
    input  logic       fim_vitoria,
    input  logic       fim_derrota,
    output logic [1:0] displayAddr,
    output logic       nivel,
    output logic       pronto,
    output logic       ocupado
);

    localparam int T_MAX = (T_LEVEL > T_BLINK) ? T_LEVEL : T_BLINK;
    localparam int PW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int BW    = $clog2(N_BLINKS + 1);

    localparam logic [PW-1:0] LEVEL_LAST = PW'(T_LEVEL - 1);
    localparam logic [PW-1:0] BLINK_LAST = PW'(T_BLINK - 1);
    localparam logic [PW-1:0] PH_ZERO    = '0;
    localparam logic [PW-1:0] PH_ONE     = PW'(1);
    localparam logic [BW-1:0] BL_FINAL   = BW'(N_BLINKS - 1);
    localparam logic [BW-1:0] BL_ZERO    = '0;
    localparam logic [BW-1:0] BL_ONE     = BW'(1);

    localparam logic [1:0] ADDR_LEVEL = 2'b00;
    localparam logic [1:0] ADDR_WIN   = 2'b01;
    localparam logic [1:0] ADDR_LOSS  = 2'b10;
    localparam logic [1:0] ADDR_BLANK = 2'b11;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHOW      = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_BLINK_ON  = 3'd3;
    localparam logic [2:0] S_BLINK_OFF = 3'd4;
    localparam logic [2:0] S_HOLD      = 3'd5;

    logic [2:0]    state,  state_n;
    logic [PW-1:0] phase,  phase_n;
    logic [BW-1:0] blinks, blinks_n;
    logic [1:0]    res,    res_n;
    logic          nivel_n;
    logic          pronto_n;
    logic          ocupado_n;
    logic [1:0]    addr_n;
    logic          start;

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        blinks_n = blinks;
        res_n    = res;
        nivel_n  = nivel;
        pronto_n = 1'b0;
        start    = 1'b0;

        case (state)
            S_IDLE: begin
                start = iniciar;
            end
            S_SHOW: begin
                if (phase == LEVEL_LAST) begin
                    state_n  = S_PLAY;
                    phase_n  = PH_ZERO;
                    pronto_n = 1'b1;
                end else begin
                    phase_n = phase + PH_ONE;
                end
            end
            S_PLAY: begin
                // A game event outranks a simultaneous restart; loss outranks win.
                if (fim_derrota || fim_vitoria) begin
                    res_n    = fim_derrota ? ADDR_LOSS : ADDR_WIN;
                    state_n  = S_BLINK_ON;
                    phase_n  = PH_ZERO;
                    blinks_n = BL_ZERO;
                end else begin
                    start = iniciar;
                end
            end
            S_BLINK_ON: begin
                if (iniciar) begin
                    start = 1'b1;
                end else if (phase == BLINK_LAST) begin
                    phase_n  = PH_ZERO;
                    blinks_n = blinks + BL_ONE;
                    state_n  = (blinks == BL_FINAL) ? S_HOLD : S_BLINK_OFF;
                end else begin
                    phase_n = phase + PH_ONE;
                end
            end
            S_BLINK_OFF: begin
                if (iniciar) begin
                    start = 1'b1;
                end else if (phase == BLINK_LAST) begin
                    phase_n = PH_ZERO;
                    state_n = S_BLINK_ON;
                end else begin
                    phase_n = phase + PH_ONE;
                end
            end
            S_HOLD: begin
                start = iniciar;
            end
            default: begin
                state_n = S_IDLE;
                phase_n = PH_ZERO;
            end
        endcase

        if (start) begin
            state_n  = S_SHOW;
            phase_n  = PH_ZERO;
            blinks_n = BL_ZERO;
            nivel_n  = nivel_in;
        end
    end

    // Outputs are derived from the next state so they appear right after the edge.
    always_comb begin
        addr_n    = ADDR_BLANK;
        ocupado_n = 1'b0;
        case (state_n)
            S_SHOW: begin
                addr_n    = ADDR_LEVEL;
                ocupado_n = 1'b1;
            end
            S_BLINK_ON: begin
                addr_n    = res_n;
                ocupado_n = 1'b1;
            end
            S_BLINK_OFF: begin
                ocupado_n = 1'b1;
            end
            S_HOLD: begin
                addr_n = res_n;
            end
            default: begin
                addr_n    = ADDR_BLANK;
                ocupado_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            phase       <= PH_ZERO;
            blinks      <= BL_ZERO;
            res         <= ADDR_BLANK;
            nivel       <= 1'b0;
            pronto      <= 1'b0;
            ocupado     <= 1'b0;
            displayAddr <= ADDR_BLANK;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            blinks      <= blinks_n;
            res         <= res_n;
            nivel       <= nivel_n;
            pronto      <= pronto_n;
            ocupado     <= ocupado_n;
            displayAddr <= addr_n;
        end
    end

endmodule
`default_nettype wire
